// File: rtl/bcd_entry_pkg.sv
// Shared types, button indices and helpers for the BCD keypad front end.
// BCD_ENTRY_DEBOUNCE_EN enables the post-event lockout in bcd_key_event.
package bcd_entry_pkg;

  typedef enum logic [1:0] {
    ENTER_A     = 2'd0,
    ENTER_B     = 2'd1,
    SHOW_RESULT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    KEY_DIGIT,
    KEY_ADD,
    KEY_EQ,
    KEY_CE,
    KEY_CA,
    KEY_NONE
  } key_t;

  localparam int unsigned PB_ADD = 16;
  localparam int unsigned PB_EQ  = 17;
  localparam int unsigned PB_CE  = 18;
  localparam int unsigned PB_CA  = 19;

  localparam int unsigned LOCKOUT_CYCLES = 5;

  // Entry-state enables: digits below the count, plus digit 0 always.
  function automatic logic [3:0] entry_en(input logic [2:0] cnt);
    logic [3:0] en;
    for (int unsigned i = 0; i < 4; i++)
      en[i] = (3'(i) < cnt) || (i == 0);
    return en;
  endfunction

  // Result enables: blank leading zeros, keep digit 0 lit.
  function automatic logic [3:0] result_en(input logic [15:0] r);
    return {|r[15:12], |r[15:8], |r[15:4], 1'b1};
  endfunction

endpackage

// File: rtl/bcd_key_event.sv
// Push-button synchronizer, rising-edge detect and priority encoder.
// BCD_ENTRY_DEBOUNCE_EN adds a lockout that drops edges after each accepted event.
module bcd_key_event
  import bcd_entry_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] pb,
  output logic        key_valid,
  output key_t        key,
  output logic [3:0]  digit
);

  logic [20:0] sync1, sync2, prev;
  logic [20:0] rises;
  key_t        key_nx;
  logic [3:0]  digit_nx;
  logic        accept;
  logic        unused_pb;

  assign unused_pb = ^{rises[20], rises[15:10]};
  assign rises     = sync2 & ~prev;

  // Lowest digit wins among digits; later checks override in rising priority.
  always_comb begin
    key_nx   = KEY_NONE;
    digit_nx = '0;
    for (int unsigned i = 10; i > 0; i--) begin
      if (rises[i-1]) begin
        key_nx   = KEY_DIGIT;
        digit_nx = 4'(i - 1);
      end
    end
    if (rises[PB_ADD]) key_nx = KEY_ADD;
    if (rises[PB_EQ])  key_nx = KEY_EQ;
    if (rises[PB_CE])  key_nx = KEY_CE;
    if (rises[PB_CA])  key_nx = KEY_CA;
  end

`ifdef BCD_ENTRY_DEBOUNCE_EN
  logic [2:0] lock;

  assign accept = (key_nx != KEY_NONE) && (lock == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              lock <= '0;
    else if (accept)      lock <= 3'(LOCKOUT_CYCLES);
    else if (lock != '0)  lock <= lock - 3'd1;
  end
`else
  assign accept = (key_nx != KEY_NONE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      key_valid <= 1'b0;
      key       <= KEY_NONE;
      digit     <= '0;
    end else begin
      sync1     <= pb;
      sync2     <= sync1;
      prev      <= sync2;
      key_valid <= accept;
      key       <= accept ? key_nx : KEY_NONE;
      digit     <= digit_nx;
    end
  end

endmodule

// File: rtl/bcd_operand_entry.sv
// Keypad entry FSM building two BCD operands and latching the adder result.
// Build with BCD_ENTRY_DEBOUNCE_EN to enable key lockout in bcd_key_event.
module bcd_operand_entry
  import bcd_entry_pkg::*;
(
  input  logic        hz100,
  input  logic        reset,
  input  logic [20:0] pb,
  input  logic [15:0] sum,
  input  logic        co,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [15:0] disp,
  output logic [3:0]  digit_en,
  output logic        carry,
  output logic [1:0]  state
);

  logic       key_valid;
  key_t       key;
  logic [3:0] digit;

  bcd_key_event u_keys (
    .clk       (hz100),
    .rst       (reset),
    .pb        (pb),
    .key_valid (key_valid),
    .key       (key),
    .digit     (digit)
  );

  state_t      cur, cur_nx;
  logic [15:0] a, a_nx, b, b_nx, res, res_nx;
  logic [2:0]  cnt_a, cnt_a_nx, cnt_b, cnt_b_nx;
  logic        cy, cy_nx;
  logic        do_clear;

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      cur   <= ENTER_A;
      a     <= '0;
      b     <= '0;
      res   <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      cy    <= 1'b0;
    end else begin
      cur   <= cur_nx;
      a     <= a_nx;
      b     <= b_nx;
      res   <= res_nx;
      cnt_a <= cnt_a_nx;
      cnt_b <= cnt_b_nx;
      cy    <= cy_nx;
    end
  end

  // Clear-entry in SHOW_RESULT shares the clear-all path.
  assign do_clear = key_valid &&
                    ((key == KEY_CA) || (key == KEY_CE && cur == SHOW_RESULT));

  always_comb begin
    cur_nx   = cur;
    a_nx     = a;
    b_nx     = b;
    res_nx   = res;
    cnt_a_nx = cnt_a;
    cnt_b_nx = cnt_b;
    cy_nx    = cy;
    if (do_clear) begin
      cur_nx   = ENTER_A;
      a_nx     = '0;
      b_nx     = '0;
      res_nx   = '0;
      cnt_a_nx = '0;
      cnt_b_nx = '0;
      cy_nx    = 1'b0;
    end else if (key_valid) begin
      unique case (cur)
        ENTER_A: begin
          if (key == KEY_DIGIT && cnt_a != 3'd4) begin
            a_nx     = {a[11:0], digit};
            cnt_a_nx = cnt_a + 3'd1;
          end else if (key == KEY_CE && cnt_a != 3'd0) begin
            a_nx     = {4'h0, a[15:4]};
            cnt_a_nx = cnt_a - 3'd1;
          end else if (key == KEY_ADD) begin
            b_nx     = '0;
            cnt_b_nx = '0;
            cur_nx   = ENTER_B;
          end
        end
        ENTER_B: begin
          if (key == KEY_DIGIT && cnt_b != 3'd4) begin
            b_nx     = {b[11:0], digit};
            cnt_b_nx = cnt_b + 3'd1;
          end else if (key == KEY_CE && cnt_b != 3'd0) begin
            b_nx     = {4'h0, b[15:4]};
            cnt_b_nx = cnt_b - 3'd1;
          end else if (key == KEY_EQ) begin
            res_nx = sum;
            cy_nx  = co;
            cur_nx = SHOW_RESULT;
          end else if (key == KEY_ADD) begin
            a_nx     = sum;
            cy_nx    = co;
            b_nx     = '0;
            cnt_b_nx = '0;
          end
        end
        SHOW_RESULT: begin
          if (key == KEY_DIGIT) begin
            a_nx     = {12'h000, digit};
            cnt_a_nx = 3'd1;
            b_nx     = '0;
            cnt_b_nx = '0;
            cy_nx    = 1'b0;
            cur_nx   = ENTER_A;
          end else if (key == KEY_ADD) begin
            a_nx     = res;
            cnt_a_nx = 3'd4;
            b_nx     = '0;
            cnt_b_nx = '0;
            cur_nx   = ENTER_B;
          end
        end
        default: cur_nx = ENTER_A;
      endcase
    end
  end

  always_comb begin
    op_a  = a;
    op_b  = b;
    carry = cy;
    state = cur;
    unique case (cur)
      ENTER_A: begin
        disp     = a;
        digit_en = entry_en(cnt_a);
      end
      ENTER_B: begin
        disp     = b;
        digit_en = entry_en(cnt_b);
      end
      SHOW_RESULT: begin
        disp     = res;
        digit_en = result_en(res);
      end
      default: begin
        disp     = '0;
        digit_en = 4'b0001;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry with a behavioural BCD adder on sum/co.
// Build with BCD_ENTRY_DEBOUNCE_EN to exercise the lockout expectation.
module tb_bcd_operand_entry;

  logic        hz100 = 1'b0;
  logic        reset;
  logic [20:0] pb;
  logic [15:0] sum;
  logic        co;
  logic [15:0] op_a, op_b, disp;
  logic [3:0]  digit_en;
  logic        carry;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] disp;
    logic [3:0]  en;
    logic        cy;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];

  bcd_operand_entry dut (
    .hz100    (hz100),
    .reset    (reset),
    .pb       (pb),
    .sum      (sum),
    .co       (co),
    .op_a     (op_a),
    .op_b     (op_b),
    .disp     (disp),
    .digit_en (digit_en),
    .carry    (carry),
    .state    (state)
  );

  always #5 hz100 = ~hz100;

  function automatic logic [16:0] bcd_add(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] r;
    logic        c;
    logic [4:0]  d;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      d = 5'(x[i*4 +: 4]) + 5'(y[i*4 +: 4]) + 5'(c);
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = d[3:0];
    end
    r[16] = c;
    return r;
  endfunction

  always_comb {co, sum} = bcd_add(op_a, op_b);

  task automatic cmp(input string tag, input string fld,
                     input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] d, input logic [3:0] en,
                            input logic cy, input logic [1:0] st);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.disp = d; e.en = en; e.cy = cy; e.st = st;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "op_a", op_a, e.a);
      cmp(e.tag, "op_b", op_b, e.b);
      cmp(e.tag, "disp", disp, e.disp);
      cmp(e.tag, "digit_en", 16'(digit_en), 16'(e.en));
      cmp(e.tag, "carry", 16'(carry), 16'(e.cy));
      cmp(e.tag, "state", 16'(state), 16'(e.st));
    end
  endtask

  // Two-cycle press then enough idle cycles to clear pipeline and lockout.
  task automatic key(input int idx);
    @(negedge hz100);
    pb[idx] = 1'b1;
    repeat (2) @(negedge hz100);
    pb[idx] = 1'b0;
    repeat (8) @(negedge hz100);
  endtask

  initial begin
    reset = 1'b1;
    pb    = '0;
    repeat (2) @(negedge hz100);
    expect_out("reset", 16'h0000, 16'h0000, 16'h0000, 4'b0001, 1'b0, 2'd0);
    check_pop();
    reset = 1'b0;

    // Five digits: fifth is ignored.
    expect_out("five_digits", 16'h1234, 16'h0000, 16'h1234, 4'hF, 1'b0, 2'd0);
    key(1); key(2); key(3); key(4); key(5);
    check_pop();

    // 9876 + 3333 = 13209.
    key(19);
    key(9); key(8); key(7); key(6);
    expect_out("add_9876", 16'h9876, 16'h0000, 16'h0000, 4'b0001, 1'b0, 2'd1);
    key(16);
    check_pop();
    expect_out("eq_3209", 16'h9876, 16'h3333, 16'h3209, 4'hF, 1'b1, 2'd2);
    key(3); key(3); key(3); key(3); key(17);
    check_pop();
    expect_out("digit_after_result", 16'h0007, 16'h0000, 16'h0007, 4'b0001, 1'b0, 2'd0);
    key(7);
    check_pop();

    // Chained add: 12 + 30, then + 1.
    key(19);
    key(1); key(2); key(16); key(3); key(0);
    expect_out("chain_add", 16'h0042, 16'h0000, 16'h0000, 4'b0001, 1'b0, 2'd1);
    key(16);
    check_pop();
    expect_out("chain_eq", 16'h0042, 16'h0001, 16'h0043, 4'b0011, 1'b0, 2'd2);
    key(1); key(17);
    check_pop();
    expect_out("result_add", 16'h0043, 16'h0000, 16'h0000, 4'b0001, 1'b0, 2'd1);
    key(16);
    check_pop();

    // Backspace down to and past empty.
    key(19);
    key(1); key(2); key(3);
    expect_out("ce_twice", 16'h0001, 16'h0000, 16'h0001, 4'b0001, 1'b0, 2'd0);
    key(18); key(18);
    check_pop();
    expect_out("ce_empty", 16'h0000, 16'h0000, 16'h0000, 4'b0001, 1'b0, 2'd0);
    key(18); key(18);
    check_pop();
    expect_out("eq_ignored_a", 16'h0000, 16'h0000, 16'h0000, 4'b0001, 1'b0, 2'd0);
    key(17);
    check_pop();

    // Digit 5 and add in the same cycle: add wins.
    key(19);
    expect_out("simul_add", 16'h0000, 16'h0000, 16'h0000, 4'b0001, 1'b0, 2'd1);
    @(negedge hz100);
    pb[5]  = 1'b1;
    pb[16] = 1'b1;
    repeat (2) @(negedge hz100);
    pb[5]  = 1'b0;
    pb[16] = 1'b0;
    repeat (8) @(negedge hz100);
    check_pop();

    // Held key yields one digit.
    expect_out("held_5", 16'h0000, 16'h0005, 16'h0005, 4'b0001, 1'b0, 2'd1);
    @(negedge hz100);
    pb[5] = 1'b1;
    repeat (20) @(negedge hz100);
    pb[5] = 1'b0;
    repeat (8) @(negedge hz100);
    check_pop();

    // Quick re-press of 3, two cycles apart.
`ifdef BCD_ENTRY_DEBOUNCE_EN
    expect_out("repress", 16'h0000, 16'h0053, 16'h0053, 4'b0011, 1'b0, 2'd1);
`else
    expect_out("repress", 16'h0000, 16'h0533, 16'h0533, 4'b0111, 1'b0, 2'd1);
`endif
    @(negedge hz100); pb[3] = 1'b1;
    @(negedge hz100); pb[3] = 1'b0;
    @(negedge hz100); pb[3] = 1'b1;
    @(negedge hz100); pb[3] = 1'b0;
    repeat (10) @(negedge hz100);
    check_pop();

    // Async reset mid-entry, B = 0042.
    key(19);
    key(16); key(4); key(2);
    expect_out("pre_reset", 16'h0000, 16'h0042, 16'h0042, 4'b0011, 1'b0, 2'd1);
    check_pop();
    expect_out("async_reset", 16'h0000, 16'h0000, 16'h0000, 4'b0001, 1'b0, 2'd0);
    @(posedge hz100);
    #2 reset = 1'b1;
    #1 check_pop();

    // Key held through reset release gives a single event.
    pb[6] = 1'b1;
    @(negedge hz100);
    reset = 1'b0;
    expect_out("held_thru_reset", 16'h0006, 16'h0000, 16'h0006, 4'b0001, 1'b0, 2'd0);
    repeat (12) @(negedge hz100);
    check_pop();
    pb[6] = 1'b0;
    repeat (4) @(negedge hz100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
